// File: rtl/neopix_rx.sv
// neopix_rx: WS2812 single-wire stream decoder.
// Measures high/low pulse widths on the synchronised DI line, recovers GRB
// bits MSB first, emits one 24-bit pixel per LED slot and a frame-end strobe.
// Optional statistics outputs (FRAME_PIXELS, FRAME_COUNT) are built only
// when the macro NEOPIX_RX_STATS_EN is defined.
module neopix_rx #(
  parameter int unsigned NUM_LEDS      = 256,
  parameter int unsigned BIT_THRESH    = 30,
  parameter int unsigned MAX_HIGH_CLKS = 75,
  parameter int unsigned RESET_CLKS    = 2500
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          DI,
  output logic [23:0]                   PIX_DATA,
  output logic                          PIX_VALID,
  output logic [$clog2(NUM_LEDS)-1:0]   PIX_INDEX,
  output logic                          FRAME_END,
  output logic                          ERROR
`ifdef NEOPIX_RX_STATS_EN
  ,
  output logic [$clog2(NUM_LEDS+1)-1:0] FRAME_PIXELS,
  output logic [15:0]                   FRAME_COUNT
`endif
);

  localparam int unsigned IDX_W  = $clog2(NUM_LEDS);
  localparam int unsigned HCNT_W = $clog2(MAX_HIGH_CLKS + 2);
  localparam int unsigned LCNT_W = $clog2(RESET_CLKS + 1);

  localparam logic [HCNT_W-1:0] HIGH_MAX  = HCNT_W'(MAX_HIGH_CLKS);
  localparam logic [HCNT_W-1:0] HIGH_SAT  = HCNT_W'(MAX_HIGH_CLKS + 1);
  localparam logic [HCNT_W-1:0] BIT_MIN   = HCNT_W'(BIT_THRESH);
  localparam logic [LCNT_W-1:0] LOW_SAT   = LCNT_W'(RESET_CLKS);
  localparam logic [IDX_W-1:0]  LAST_SLOT = IDX_W'(NUM_LEDS - 1);

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  logic              sync1;
  logic              ds;
  logic              ds_prev;
  logic              rise;
  logic              fall;
  logic [1:0]        state;
  logic [HCNT_W-1:0] high_cnt;
  logic [HCNT_W-1:0] high_inc;
  logic [LCNT_W-1:0] low_cnt;
  logic [LCNT_W-1:0] low_inc;
  logic [4:0]        bit_cnt;
  logic [22:0]       shift_reg;
  logic [23:0]       shift_next;
  logic              bit_val;
  logic              too_long;
  logic              last_bit;
  logic              slots_full;
  logic              frame_start;
  logic              frame_done;
  logic              emit;

  // Two-flop synchroniser for DI plus one delayed copy for edge detection.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1   <= 1'b0;
      ds      <= 1'b0;
      ds_prev <= 1'b0;
    end else begin
      sync1   <= DI;
      ds      <= sync1;
      ds_prev <= ds;
    end
  end

  // Edge detection, saturating counter increments and decode decisions.
  always_comb begin
    rise        = ds & ~ds_prev;
    fall        = ~ds & ds_prev;
    high_inc    = (high_cnt == HIGH_SAT) ? high_cnt : high_cnt + HCNT_W'(1);
    low_inc     = (low_cnt == LOW_SAT) ? low_cnt : low_cnt + LCNT_W'(1);
    bit_val     = (high_cnt >= BIT_MIN);
    shift_next  = {shift_reg, bit_val};
    too_long    = (high_cnt > HIGH_MAX);
    last_bit    = (bit_cnt == 5'd23);
    frame_start = (state == ST_IDLE) && rise;
    frame_done  = (state == ST_LOW) && !rise && (low_inc == LOW_SAT);
    // the malformed-pulse check outranks a falling edge in the same cycle
    emit        = (state == ST_HIGH) && !too_long && fall && last_bit && !slots_full;
  end

  // Decoder state machine: pulse measurement, bit assembly, pixel/frame strobes.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_SYNC;
      high_cnt   <= '0;
      low_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      slots_full <= 1'b0;
      PIX_DATA   <= '0;
      PIX_VALID  <= 1'b0;
      PIX_INDEX  <= '0;
      FRAME_END  <= 1'b0;
      ERROR      <= 1'b0;
    end else begin
      PIX_VALID <= emit;
      FRAME_END <= frame_done;
      // index advances the cycle after each strobe but holds on the last slot
      if (PIX_VALID && (PIX_INDEX != LAST_SLOT)) begin
        PIX_INDEX <= PIX_INDEX + IDX_W'(1);
      end
      case (state)
        ST_SYNC: begin
          if (ds) begin
            low_cnt <= '0;
          end else if (low_inc == LOW_SAT) begin
            low_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            low_cnt <= low_inc;
          end
        end
        ST_IDLE: begin
          if (frame_start) begin
            state      <= ST_HIGH;
            high_cnt   <= HCNT_W'(1);
            bit_cnt    <= '0;
            PIX_INDEX  <= '0;
            slots_full <= 1'b0;
          end
        end
        ST_HIGH: begin
          if (too_long) begin
            ERROR   <= 1'b1;
            low_cnt <= '0;
            state   <= ST_SYNC;
          end else if (fall) begin
            shift_reg <= shift_next[22:0];
            low_cnt   <= LCNT_W'(1);
            state     <= ST_LOW;
            if (last_bit) begin
              bit_cnt <= '0;
              if (slots_full) begin
                ERROR <= 1'b1;
              end else begin
                PIX_DATA <= shift_next;
                if (PIX_INDEX == LAST_SLOT) begin
                  slots_full <= 1'b1;
                end
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else begin
            high_cnt <= high_inc;
          end
        end
        ST_LOW: begin
          if (rise) begin
            high_cnt <= HCNT_W'(1);
            state    <= ST_HIGH;
          end else if (frame_done) begin
            if (bit_cnt != 5'd0) begin
              ERROR <= 1'b1;
            end
            low_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            low_cnt <= low_inc;
          end
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

`ifdef NEOPIX_RX_STATS_EN
  logic [$clog2(NUM_LEDS+1)-1:0] pix_count;

  // Per-frame pixel tally and wrapping frame counter, latched at frame end.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pix_count    <= '0;
      FRAME_PIXELS <= '0;
      FRAME_COUNT  <= '0;
    end else begin
      if (frame_start) begin
        pix_count <= '0;
      end else if (emit) begin
        pix_count <= pix_count + 1'b1;
      end
      if (frame_done) begin
        FRAME_PIXELS <= pix_count;
        FRAME_COUNT  <= FRAME_COUNT + 16'd1;
      end
    end
  end
`else
  // statistics outputs and their counters are not built in this configuration
`endif

endmodule
